// File: rtl/counter_pkg.sv
// Shared constants for the parametrised up/down counter.
// Mode encodings and ping-pong direction values.
package counter_pkg;
    localparam logic [1:0] MODE_WRAP     = 2'd0;
    localparam logic [1:0] MODE_SAT      = 2'd1;
    localparam logic [1:0] MODE_ONESHOT  = 2'd2;
    localparam logic [1:0] MODE_PINGPONG = 2'd3;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/param_updown_counter_if.sv
// Control and status bundle for the up/down counter.
// master drives controls, slave is the counter itself.
interface param_updown_counter_if #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic [1:0]       mode;
    logic [WIDTH-1:0] limit;
    logic [PRE_W-1:0] prescale;
    logic [WIDTH-1:0] cmp_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             cmp_match;
    logic             done;
    logic             ovf;

    modport master (
        output clear, load, load_val, en, up, mode,
        output limit, prescale, cmp_val,
        input  q, tc, cmp_match, done, ovf
    );

    modport slave (
        input  clear, load, load_val, en, up, mode,
        input  limit, prescale, cmp_val,
        output q, tc, cmp_match, done, ovf
    );
endinterface

// File: rtl/counter_prescaler.sv
// Clock-enable divider: one step every prescale+1 enabled cycles.
// restart drops any partial count and suppresses the step.
module counter_prescaler #(
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             en,
    input  logic [PRE_W-1:0] prescale,
    output logic             step
);
    logic [PRE_W-1:0] pre_cnt_q;
    logic [PRE_W-1:0] pre_cnt_d;
    logic             hit;

    assign hit  = (pre_cnt_q == prescale);
    assign step = en & ~restart & hit;

    // next prescale count: clear on restart, advance while enabled
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (restart) begin
            pre_cnt_d = '0;
        end else if (en) begin
            pre_cnt_d = hit ? '0 : pre_cnt_q + PRE_W'(1);
        end
    end

    // prescale count register
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end
endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with prescaler and four modes.
// Modes: wrap, saturate, one-shot and ping-pong.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input logic                  clk,
    input logic                  rst,
    param_updown_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             dir_q, dir_d;
    logic             step;
    logic             restart;
    logic             cnt_en;
    logic             at_top;
    logic             at_bot;
    logic             lim_zero;

    assign restart  = bus.clear | bus.load;
    assign cnt_en   = bus.en & ~done_q;
    assign at_top   = (q_q >= bus.limit);
    assign at_bot   = (q_q == '0);
    assign lim_zero = (bus.limit == '0);

    counter_prescaler #(
        .PRE_W(PRE_W)
    ) u_pre (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .en       (cnt_en),
        .prescale (bus.prescale),
        .step     (step)
    );

    // next count state: clear > load > mode-dependent step
    always_comb begin
        q_d    = q_q;
        tc_d   = 1'b0;
        done_d = done_q;
        ovf_d  = ovf_q;
        dir_d  = dir_q;
        if (bus.clear) begin
            q_d    = '0;
            done_d = 1'b0;
            ovf_d  = 1'b0;
            dir_d  = DIR_UP;
        end else if (bus.load) begin
            q_d    = bus.load_val;
            done_d = 1'b0;
            dir_d  = DIR_UP;
        end else if (step) begin
            case (bus.mode)
                MODE_WRAP: begin
                    if (bus.up) begin
                        if (at_top) begin
                            q_d   = '0;
                            tc_d  = 1'b1;
                            ovf_d = 1'b1;
                        end else begin
                            q_d = q_q + ONE;
                        end
                    end else begin
                        if (at_bot) begin
                            q_d   = bus.limit;
                            tc_d  = 1'b1;
                            ovf_d = 1'b1;
                        end else begin
                            q_d = q_q - ONE;
                        end
                    end
                end
                MODE_SAT, MODE_ONESHOT: begin
                    if (bus.up ? at_top : at_bot) begin
                        tc_d = 1'b1;
                        if (bus.mode == MODE_SAT) begin
                            ovf_d = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else if (bus.up) begin
                        q_d = q_q + ONE;
                    end else begin
                        q_d = q_q - ONE;
                    end
                end
                default: begin
                    if (dir_q == DIR_UP && at_top) begin
                        dir_d = DIR_DOWN;
                        q_d   = lim_zero ? '0 : bus.limit - ONE;
                        tc_d  = 1'b1;
                    end else if (dir_q == DIR_DOWN && at_bot) begin
                        dir_d = DIR_UP;
                        q_d   = lim_zero ? '0 : ONE;
                        tc_d  = 1'b1;
                    end else if (dir_q == DIR_UP) begin
                        q_d = q_q + ONE;
                    end else begin
                        q_d = q_q - ONE;
                    end
                end
            endcase
        end
    end

    // counter state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            dir_q  <= DIR_UP;
        end else begin
            q_q    <= q_d;
            tc_q   <= tc_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
            dir_q  <= dir_d;
        end
    end

    assign bus.q         = q_q;
    assign bus.tc        = tc_q;
    assign bus.done      = done_q;
    assign bus.ovf       = ovf_q;
    assign bus.cmp_match = (q_q == bus.cmp_val);
endmodule
